// File: rtl/hex_display_ctrl_if.sv
// Bus between datapath logic and the hex display controller: value strobes,
// display options and the registered display outputs.
interface hex_display_ctrl_if #(
  parameter int DIGITS = 6
);
  logic                  load;
  logic [4*DIGITS-1:0]   value_in;
  logic                  inc;
  logic                  dec;
  logic                  blank_lz;
  logic [DIGITS-1:0]     blink_mask;
  logic [4*DIGITS-1:0]   value_q;
  logic [7*DIGITS-1:0]   hex_out;
  logic                  blink_phase;

  modport master (
    output load, value_in, inc, dec, blank_lz, blink_mask,
    input  value_q, hex_out, blink_phase
  );

  modport slave (
    input  load, value_in, inc, dec, blank_lz, blink_mask,
    output value_q, hex_out, blink_phase
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display controller: held value with load/inc/dec, registered
// seven-segment fields with leading-zero blanking and per-digit blinking.
module hex_display_ctrl #(
  parameter int DIGITS     = 6,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int BLINK_DIV  = 25_000_000
) (
  input logic             clock,
  input logic             reset,
  hex_display_ctrl_if.slave bus
);

  localparam int            CW    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] TERM  = CW'(BLINK_DIV - 1);
  localparam logic [6:0]    BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [4*DIGITS-1:0] value_r;
  logic [CW-1:0]       div_cnt;
  logic                phase_r;
  logic [7*DIGITS-1:0] hex_r;
  logic [7*DIGITS-1:0] hex_d;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // load wins over inc/dec; inc and dec together cancel out
  always_ff @(posedge clock) begin
    if (reset) begin
      value_r <= '0;
    end else if (bus.load) begin
      value_r <= bus.value_in;
    end else if (bus.inc && !bus.dec) begin
      value_r <= value_r + 1'b1;
    end else if (bus.dec && !bus.inc) begin
      value_r <= value_r - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      phase_r <= 1'b0;
    end else if (div_cnt == TERM) begin
      div_cnt <= '0;
      phase_r <= ~phase_r;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // Scan from the most significant digit so upper_zero tracks "all digits above are 0"
  always_comb begin
    logic       upper_zero;
    logic [3:0] digit;
    logic [6:0] lit;
    hex_d      = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit      = value_r[4*k +: 4];
      upper_zero = upper_zero && (digit == 4'h0);
      lit        = glyph(digit);
      if ((bus.blink_mask[k] && phase_r) || (bus.blank_lz && upper_zero && (k != 0))) begin
        lit = 7'h00;
      end
      hex_d[7*k +: 7] = ACTIVE_LOW ? ~lit : lit;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hex_r <= {DIGITS{BLANK}};
    end else begin
      hex_r <= hex_d;
    end
  end

  assign bus.value_q     = value_r;
  assign bus.hex_out     = hex_r;
  assign bus.blink_phase = phase_r;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: two configurations driven side by side and
// compared every cycle against an arithmetic model of the display rules.
module tb_hex_display_ctrl;

  localparam int DA  = 6;
  localparam int BDA = 4;
  localparam int DB  = 2;
  localparam int BDB = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  longint unsigned ma_v, mb_v;
  longint          ma_n, mb_n;
  logic [55:0]     ma_hex, mb_hex;

  hex_display_ctrl_if #(.DIGITS(DA)) ifa ();
  hex_display_ctrl_if #(.DIGITS(DB)) ifb ();

  hex_display_ctrl #(.DIGITS(DA), .ACTIVE_LOW(1'b1), .BLINK_DIV(BDA)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa.slave));
  hex_display_ctrl #(.DIGITS(DB), .ACTIVE_LOW(1'b0), .BLINK_DIV(BDB)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb.slave));

  always #5 clock = ~clock;

  function automatic longint unsigned next_value(longint unsigned v, int digits, logic ld,
                                                 longint unsigned vin, logic inc, logic dec);
    longint unsigned modulus = longint'(1) << (4 * digits);
    if (ld) return vin;
    if (inc && !dec) return (v + 1) % modulus;
    if (dec && !inc) return (v + modulus - 1) % modulus;
    return v;
  endfunction

  function automatic logic phase_of(longint n, int bd);
    return logic'((n / bd) % 2);
  endfunction

  // Field k is blank when blinked, or when blank_lz is set and k lies above the
  // highest nonzero digit (digit 0 always shown)
  function automatic logic [55:0] render(longint unsigned v, int digits, bit al, logic blz,
                                         logic [7:0] mask, logic ph);
    logic [55:0] r = '0;
    logic [6:0]  lit;
    int          top = -1;
    for (int k = 0; k < digits; k++)
      if (((v >> (4 * k)) & 15) != 0) top = k;
    for (int k = 0; k < digits; k++) begin
      lit = glyph_tab[int'((v >> (4 * k)) & 15)];
      if ((mask[k] && ph) || (blz && k > top && k != 0)) lit = 7'h00;
      r[7*k +: 7] = al ? ~lit : lit;
    end
    return r;
  endfunction

  task automatic check(string tag, logic [55:0] obs, logic [55:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge: predict from pre-edge inputs/state, then compare after the edge
  task automatic applyStimulus();
    longint unsigned na_v, nb_v;
    longint          na_n, nb_n;
    logic [55:0]     na_hex, nb_hex;
    if (reset) begin
      na_v = 0; na_n = 0; na_hex = render(0, DA, 1, 0, 8'hFF, 1);
      nb_v = 0; nb_n = 0; nb_hex = render(0, DB, 0, 0, 8'hFF, 1);
    end else begin
      na_v   = next_value(ma_v, DA, ifa.load, longint'(ifa.value_in), ifa.inc, ifa.dec);
      na_n   = ma_n + 1;
      na_hex = render(ma_v, DA, 1, ifa.blank_lz, 8'(ifa.blink_mask), phase_of(ma_n, BDA));
      nb_v   = next_value(mb_v, DB, ifb.load, longint'(ifb.value_in), ifb.inc, ifb.dec);
      nb_n   = mb_n + 1;
      nb_hex = render(mb_v, DB, 0, ifb.blank_lz, 8'(ifb.blink_mask), phase_of(mb_n, BDB));
    end
    @(posedge clock);
    #1;
    ma_v = na_v; ma_n = na_n; ma_hex = na_hex;
    mb_v = nb_v; mb_n = nb_n; mb_hex = nb_hex;
    checkOutput();
  endtask

  task automatic checkOutput();
    check("a_value_q", 56'(ifa.value_q), 56'(ma_v[4*DA-1:0]));
    check("a_blink_phase", 56'(ifa.blink_phase), 56'(phase_of(ma_n, BDA)));
    check("a_hex_out", 56'(ifa.hex_out), 56'(ma_hex[7*DA-1:0]));
    check("b_value_q", 56'(ifb.value_q), 56'(mb_v[4*DB-1:0]));
    check("b_blink_phase", 56'(ifb.blink_phase), 56'(phase_of(mb_n, BDB)));
    check("b_hex_out", 56'(ifb.hex_out), 56'(mb_hex[7*DB-1:0]));
  endtask

  task automatic clearStrobes();
    ifa.load = 0; ifa.inc = 0; ifa.dec = 0;
    ifb.load = 0; ifb.inc = 0; ifb.dec = 0;
  endtask

  initial begin
    ma_v = 0; mb_v = 0; ma_n = 0; mb_n = 0; ma_hex = '0; mb_hex = '0;
    clearStrobes();
    ifa.value_in = '0; ifa.blank_lz = 0; ifa.blink_mask = '0;
    ifb.value_in = '0; ifb.blank_lz = 0; ifb.blink_mask = '0;

    reset = 1;
    applyStimulus();
    check("reset_hex_blank", 56'(ifa.hex_out), 56'({DA{7'h7F}}));
    applyStimulus();
    reset = 0;
    applyStimulus();
    check("zero_display", 56'(ifa.hex_out), 56'({DA{7'h40}}));

    // Load with leading-zero blanking on both configurations
    ifa.blank_lz = 1; ifa.load = 1; ifa.value_in = 24'h00A3F1;
    ifb.load = 1; ifb.value_in = 8'h8C;
    applyStimulus();
    clearStrobes();
    applyStimulus();
    check("a3f1_fields", 56'(ifa.hex_out),
          56'({7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h79}));
    check("b_8c_fields", 56'(ifb.hex_out), 56'({7'h7F, 7'h39}));

    // Wrap-around and strobe priority
    ifa.load = 1; ifa.value_in = 24'hFFFFFF; applyStimulus(); clearStrobes();
    ifa.inc = 1; applyStimulus(); clearStrobes();
    check("inc_wrap", 56'(ifa.value_q), 56'h0);
    ifa.dec = 1; applyStimulus(); clearStrobes();
    check("dec_wrap", 56'(ifa.value_q), 56'hFFFFFF);
    ifa.inc = 1; ifa.dec = 1; applyStimulus(); clearStrobes();
    ifa.load = 1; ifa.inc = 1; ifa.value_in = 24'h123456; applyStimulus(); clearStrobes();
    check("load_over_inc", 56'(ifa.value_q), 56'h123456);

    // Blinking digit 0 from a fresh reset
    reset = 1; applyStimulus(); reset = 0;
    ifa.blank_lz = 0; ifa.blink_mask = 6'b000001; ifa.load = 1; ifa.value_in = 24'h000005;
    ifb.blink_mask = 2'b11; ifb.load = 1; ifb.value_in = 8'h8C;
    applyStimulus(); clearStrobes();
    for (int i = 0; i < 14; i++) applyStimulus();

    // Reset mid-blink
    reset = 1; applyStimulus();
    check("b_reset_hex", 56'(ifb.hex_out), 56'h0);
    reset = 0;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      ifa.load = ($urandom_range(0, 7) == 0);
      ifa.inc  = ($urandom_range(0, 2) == 0);
      ifa.dec  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: ifa.value_in = 24'hFFFFFF;
        1: ifa.value_in = 24'($urandom_range(0, 255));
        default: ifa.value_in = 24'($urandom);
      endcase
      ifa.blank_lz   = 1'($urandom);
      ifa.blink_mask = 6'($urandom);
      ifb.load = ($urandom_range(0, 5) == 0);
      ifb.inc  = ($urandom_range(0, 2) == 0);
      ifb.dec  = ($urandom_range(0, 2) == 0);
      ifb.value_in   = 8'($urandom);
      ifb.blank_lz   = 1'($urandom);
      ifb.blink_mask = 2'($urandom);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised multi-digit hexadecimal display controller for the board's seven-segment bank. It holds a DIGITS-wide hex value that can be loaded, incremented or decremented by single-cycle strobes. It drives one seven-segment field per digit with registered outputs, and supports optional leading-zero blanking and per-digit blinking. It sits between datapath logic and the HEX pins, replacing per-digit combinational decoders.

## Interface
- DIGITS, 6, number of hex digits driven; legal range 1..8.
- ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (board pins); 0 = lit when 1.
- BLINK_DIV, 25_000_000, clock cycles per blink half-period; legal range ≥ 2.
- Clock  input  1  single clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high; overrides every other input.
- load  input  1  single-cycle strobe; captures `value_in` into the held value.
- value_in  input  4*DIGITS  new value; digit k is bits [4k+3:4k], digit 0 least significant.
- inc  input  1  strobe; held value +1 modulo 16^DIGITS.
- dec  input  1  strobe; held value −1 modulo 16^DIGITS.
- blank_lz  input  1  level; 1 = blank leading-zero digits.
- blink_mask  input  DIGITS  level; bit k = 1 makes digit k blink.
- value_q  output  4*DIGITS  current held value.
- hex_out  output  7*DIGITS  segment fields; digit k is bits [7k+6:7k], bit 0 = segment a through bit 6 = segment g.
- blink_phase  output  1  current blink phase; 1 = blinking digits hidden.

## Operation
- Held value update priority per cycle: Reset > load > (inc XOR dec) > hold.
  - inc and dec asserted together with no load: no change.
  - load together with inc or dec: only the load takes effect.
- Wrap-around:
  - All-F plus inc → all-0.
  - All-0 plus dec → all-F.
  - Arithmetic is unsigned, 4*DIGITS bits, carry and borrow are discarded.
- Glyphs, standard hex pattern with 1 = lit before polarity is applied:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Blank field: all segments unlit, i.e. 7F when ACTIVE_LOW=1 and 00 when ACTIVE_LOW=0.
- Polarity: when ACTIVE_LOW=1 every lit-pattern bit is inverted before registering.
- Leading-zero blanking, when blank_lz=1:
  - Digit k is blanked when it and every digit above it are 0.
  - Digit 0 is never blanked by this rule, so a value of 0 shows a single "0".
- Blinking:
  - Divider counter runs 0..BLINK_DIV−1 continuously.
  - On the terminal count the counter returns to 0 and blink_phase toggles.
  - While blink_phase=1, every digit with its blink_mask bit set shows the blank field.
  - Blinking takes precedence over glyph display; when a digit is both blinked and leading-zero blanked, the result is blank.
- Composition for each digit, evaluated from the held value, blank_lz, blink_mask and blink_phase as they are before the clock edge: apply the blank conditions, otherwise the glyph, then the polarity, then register.

## Timing
- Reset values:
  - value_q = 0, divider counter = 0, blink_phase = 0.
  - hex_out = blank field in every digit.
- Latency:
  - value_q changes on the edge that samples load, inc or dec.
  - hex_out reflects the new value one edge later, so load at edge n updates the display at edge n+1.
- blank_lz and blink_mask changes reach hex_out one edge after they are sampled.
- blink_phase toggles at the edge where the counter is BLINK_DIV−1. The first toggle after reset is at the BLINK_DIV-th edge following the reset release.
- The affected hex_out digits change one edge after blink_phase toggles.
- Reset asserted mid-operation: all state returns to the reset values at that edge, and the divider restarts from 0.
- No handshake; strobes are sampled every cycle. A strobe held high for m cycles acts m times.

## Test plan
- Reset with DIGITS=6, ACTIVE_LOW=1, then release: hex_out = all 7F for one cycle; the cycle after, with blank_lz=0, every field = 40 ("0"); value_q = 0.
- load value_in=0x00A3F1 with blank_lz=1: value_q = 0x00A3F1 at edge n; at edge n+1 fields 5,4 = 7F, field 3 = 08 (A), field 2 = 30 (3), field 1 = 0E (F), field 0 = 79 (1).
- load 0xFFFFFF then inc: value_q = 0x000000. Then dec: value_q = 0xFFFFFF. inc and dec together: value_q unchanged. load with inc together: value_q = value_in.
- BLINK_DIV=4, blink_mask=000001, value 0x000005, blank_lz=0:
  - blink_phase toggles every 4 cycles after reset release.
  - field 0 alternates 12 ("5") and 7F, lagging blink_phase by one cycle.
  - fields 1..5 stay 40.
- ACTIVE_LOW=0, DIGITS=2, load 0x8C: field 1 = 7F, field 0 = 39. Assert Reset mid-blink: blink_phase = 0, hex_out = 00, value_q = 0 at that edge.
